// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// Optional feature macro: BP_BHT_EN (2-bit BHT counters; otherwise 1-bit last-outcome).
package bp_pkg;

    // Architectural PC width and the width of a stored branch target.
    localparam int unsigned PcWidth    = 32;
    localparam int unsigned TargetBits = 32;

    // BTB entry field widths (the tag width also depends on the index width).
    localparam int unsigned ValidBits = 1;
    localparam int unsigned TknBits   = 1;

    // Two-bit branch history counter states.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctrState_e;

    // Counters come out of reset weakly not-taken.
    localparam ctrState_e CtrReset = WNT;

    // Tag width for a given index width: whatever is left above the index and byte offset.
    function automatic int unsigned tagBits(input int unsigned idxBits);
        return PcWidth - idxBits - 2;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating branch history counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctrState_e cnt_i,
    input  logic      taken_i,
    output ctrState_e cnt_o
);

    // Step one state toward the observed outcome, holding at SNT/ST.
    always_comb begin
        cnt_o = cnt_i;
        unique case (cnt_i)
            SNT: cnt_o = taken_i ? WNT : SNT;
            WNT: cnt_o = taken_i ? WT  : SNT;
            WT:  cnt_o = taken_i ? ST  : WNT;
            ST:  cnt_o = taken_i ? ST  : WT;
            default: cnt_o = CtrReset;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus an optional 2-bit BHT.
// Build option: define BP_BHT_EN for 2-bit counters; undefined gives 1-bit last-outcome.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        isBtbTaken,
    output logic        isBhtTaken,
    output logic [31:0] BtbPCPred,
    input  logic        UpdE,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic [31:0] BranchTargetE
);

    localparam int unsigned TAG_BITS   = tagBits(IDX_BITS);
    localparam int unsigned NumEntries = 1 << IDX_BITS;

    typedef struct packed {
        logic [ValidBits-1:0]  valid;
        logic [TAG_BITS-1:0]   tag;
        logic [TargetBits-1:0] target;
        logic [TknBits-1:0]    tkn;
    } btbEntry_t;

    btbEntry_t btb [NumEntries];

    // Address split for the lookup (fetch) and training (execute) ports.
    logic [IDX_BITS-1:0] idxF, idxE;
    logic [TAG_BITS-1:0] tagF, tagE;

    assign idxF = PCF[IDX_BITS+1:2];
    assign tagF = PCF[31:IDX_BITS+2];
    assign idxE = PCE[IDX_BITS+1:2];
    assign tagE = PCE[31:IDX_BITS+2];

    // Byte-offset bits never affect the predictor.
    logic unusedPcLow;
    assign unusedPcLow = ^{PCF[1:0], PCE[1:0]};

    btbEntry_t entF, entE;
    logic      hitF, hitE;

    assign entF = btb[idxF];
    assign entE = btb[idxE];
    assign hitF = entF.valid[0] && (entF.tag == tagF);
    assign hitE = entE.valid[0] && (entE.tag == tagE);

    // Direction bit for the looked-up entry, from the counter or the stored last outcome.
    logic predTakenF;

`ifdef BP_BHT_EN
    ctrState_e ctr [NumEntries];
    ctrState_e ctrCurE, ctrNextE;
    logic      ctrWrEn;
    logic      unusedTkn;

    assign predTakenF = ctr[idxF][1];
    assign ctrCurE    = ctr[idxE];
    assign ctrWrEn    = UpdE;
    assign unusedTkn  = entF.tkn[0];

    bp_sat_counter uCtrNext (
        .cnt_i   (ctrCurE),
        .taken_i (BranchE),
        .cnt_o   (ctrNextE)
    );

    // BHT counters: reset to weakly not-taken, trained on every resolved branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                ctr[i] <= CtrReset;
            end
        end else if (ctrWrEn) begin
            ctr[idxE] <= ctrNextE;
        end
    end
`else
    assign predTakenF = entF.tkn[0];
`endif

    // Lookup outputs; a miss or an active reset forces everything to zero.
    always_comb begin
        isBtbTaken = 1'b0;
        isBhtTaken = 1'b0;
        BtbPCPred  = '0;
        if (!rst && hitF) begin
            isBtbTaken = 1'b1;
            isBhtTaken = predTakenF;
            BtbPCPred  = entF.target;
        end
    end

    // BTB write decision: taken branches allocate/overwrite, not-taken may invalidate.
    logic      btbWrEn, btbClrEn;
    btbEntry_t btbWrData;

    always_comb begin
        btbWrEn          = 1'b0;
        btbClrEn         = 1'b0;
        btbWrData.valid  = 1'b1;
        btbWrData.tag    = tagE;
        btbWrData.target = BranchTargetE;
        btbWrData.tkn    = 1'b1;
        if (UpdE) begin
            if (BranchE) begin
                btbWrEn = 1'b1;
            end else begin
`ifdef BP_BHT_EN
                btbClrEn = 1'b0;
`else
                // Without counters, a not-taken outcome drops the entry.
                btbClrEn = hitE;
`endif
            end
        end
    end

    // BTB storage: cleared entirely on reset, reset wins over any pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                btb[i] <= '0;
            end
        end else if (btbWrEn) begin
            btb[idxE] <= btbWrData;
        end else if (btbClrEn) begin
            btb[idxE].valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor with a table-level reference model.
module tb_branch_predictor;

    localparam int Idx = 6;
    localparam int N   = 1 << Idx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        isBtbTaken;
    logic        isBhtTaken;
    logic [31:0] BtbPCPred;
    logic        UpdE;
    logic [31:0] PCE;
    logic        BranchE;
    logic [31:0] BranchTargetE;

    int checks   = 0;
    int failures = 0;

    // Reference model: one slot per index holding the last taken branch seen there.
    bit          mValid [N];
    int unsigned mTag   [N];
    logic [31:0] mTgt   [N];
    int          mCtr   [N];

    branch_predictor #(.IDX_BITS(Idx)) dut (
        .clk           (clk),
        .rst           (rst),
        .PCF           (PCF),
        .isBtbTaken    (isBtbTaken),
        .isBhtTaken    (isBhtTaken),
        .BtbPCPred     (BtbPCPred),
        .UpdE          (UpdE),
        .PCE           (PCE),
        .BranchE       (BranchE),
        .BranchTargetE (BranchTargetE)
    );

    always #5 clk = ~clk;

    function automatic int idxOf(input logic [31:0] pc);
        return int'(pc[Idx+1:2]);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        return int'(pc >> (Idx + 2));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, compare against the model's pre-edge view, then advance the model.
    task automatic step(input logic r, input logic [31:0] pcf, input logic u,
                        input logic [31:0] pce, input logic b, input logic [31:0] tgt);
        int          i;
        bit          hit;
        logic [31:0] eBtb, eBht, ePred;
        rst = r; PCF = pcf; UpdE = u; PCE = pce; BranchE = b; BranchTargetE = tgt;
        #4;
        i     = idxOf(pcf);
        hit   = !r && mValid[i] && (mTag[i] == tagOf(pcf));
`ifdef BP_BHT_EN
        eBht  = {31'd0, hit && (mCtr[i] >= 2)};
`else
        eBht  = {31'd0, hit};
`endif
        eBtb  = {31'd0, hit};
        ePred = hit ? mTgt[i] : 32'd0;
        check("model_btb", {31'd0, isBtbTaken}, eBtb);
        check("model_bht", {31'd0, isBhtTaken}, eBht);
        check("model_pred", BtbPCPred, ePred);
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < N; k++) begin
                mValid[k] = 1'b0; mTag[k] = 0; mTgt[k] = '0; mCtr[k] = 1;
            end
        end else if (u) begin
            i = idxOf(pce);
            if (b) mCtr[i] = (mCtr[i] == 3) ? 3 : mCtr[i] + 1;
            else   mCtr[i] = (mCtr[i] == 0) ? 0 : mCtr[i] - 1;
            if (b) begin
                mValid[i] = 1'b1; mTag[i] = tagOf(pce); mTgt[i] = tgt;
            end
`ifndef BP_BHT_EN
            else if (mValid[i] && mTag[i] == tagOf(pce)) begin
                mValid[i] = 1'b0;
            end
`endif
        end
        #1;
    endtask

    // Lookup-only cycle with hand-derived expectations.
    task automatic probe(input string tag, input logic [31:0] pcf, input logic eBtb,
                         input logic eBht, input logic [31:0] ePred);
        rst = 1'b0; PCF = pcf; UpdE = 1'b0; PCE = '0; BranchE = 1'b0; BranchTargetE = '0;
        #4;
        check({tag, "_btb"}, {31'd0, isBtbTaken}, {31'd0, eBtb});
        check({tag, "_bht"}, {31'd0, isBhtTaken}, {31'd0, eBht});
        check({tag, "_pred"}, BtbPCPred, ePred);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pool [8];

    initial begin
        rst = 1'b1; PCF = '0; UpdE = 1'b0; PCE = '0; BranchE = 1'b0; BranchTargetE = '0;
        @(posedge clk);
        #1;

        // Reset and cold lookup.
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        probe("cold", 32'h100, 1'b0, 1'b0, 32'h0);

        // First taken update, lookup in the same cycle sees old contents.
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
        probe("train1", 32'h100, 1'b1, 1'b1, 32'h200);

        // Saturate, then walk back down.
        step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h200);
        step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h200);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
`ifdef BP_BHT_EN
        probe("nt1", 32'h100, 1'b1, 1'b1, 32'h200);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
        probe("nt2", 32'h100, 1'b1, 1'b0, 32'h200);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
        probe("nt3", 32'h100, 1'b1, 1'b0, 32'h200);
`else
        probe("nt1", 32'h100, 1'b0, 1'b0, 32'h0);
`endif

        // Aliasing at the same index.
        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h200);
        step(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h300);
        probe("alias_old", 32'h100, 1'b0, 1'b0, 32'h0);
        probe("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);

        // Reset together with an update: the update is dropped, counters return to WNT.
        step(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h400);
        probe("rst_mid", 32'h200, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h500);
        probe("rst_ctr1", 32'h200, 1'b1, 1'b1, 32'h500);
`ifdef BP_BHT_EN
        step(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0);
        probe("rst_ctr2", 32'h200, 1'b1, 1'b0, 32'h500);
`endif

        // Randomized traffic over a small, heavily aliasing PC pool.
        for (int k = 0; k < 8; k++) begin
            pool[k] = (32'($urandom_range(0, 2)) << (Idx + 2))
                    | (32'($urandom_range(0, 3)) << 2)
                    | 32'($urandom_range(0, 3));
        end
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0),
                 pool[$urandom_range(0, 7)],
                 ($urandom_range(0, 3) != 0),
                 pool[$urandom_range(0, 7)],
                 $urandom_range(0, 1) == 1,
                 $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
